gemm_seq_ctrl: RTL
==================

# gemm_seq_ctrl

Sequencer for one tile pass through the ROWS×ROWS weight-stationary systolic GEMM array. On a start request it preloads weights, streams K input vectors, waits for the array pipeline to flush, and writes each result row back. It issues buffer read/write enables and addresses and reports completion. It sits between the top-level command interface and the weight, input and output buffers around the GEMM core.

## Interface
- ROWS, 14, array dimension; weight rows loaded per tile
- CNT_WIDTH, 5, phase-counter width; must satisfy 2^CNT_WIDTH ≥ 2*ROWS
- ADDR_WIDTH, 8, input/output buffer address width; K ≤ 2^ADDR_WIDTH − 1
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- start_i  in  1  tile request; sampled only in IDLE
- k_len_i  in  ADDR_WIDTH  input vectors per tile; latched when start is accepted
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse in DONE
- w_rd_en_o  out  1  weight buffer read and array weight-shift enable
- w_addr_o  out  CNT_WIDTH  weight row address, 0..ROWS−1
- x_rd_en_o  out  1  input buffer read enable; vector enters array
- x_addr_o  out  ADDR_WIDTH  input vector address, 0..K−1
- o_wr_en_o  out  1  output buffer write enable
- o_addr_o  out  ADDR_WIDTH  output row address, 0..K−1

## Operation
- LAT = 2*ROWS − 1 is the array latency from x_rd_en_o to the matching result. It is 27 at the default ROWS.
- States: IDLE → LOAD_W → FEED → DRAIN → DONE → IDLE.
- IDLE: all enables are 0. When start_i=1, latch k_len_i into K and go to LOAD_W. If start_i=1 and K=0, go to LOAD_W anyway, then skip FEED and DRAIN and go LOAD_W → DONE.
- LOAD_W: lasts exactly ROWS cycles. w_rd_en_o=1 and w_addr_o counts 0..ROWS−1. On the last cycle (w_addr_o=ROWS−1), go to FEED (or to DONE if K=0).
- FEED: lasts exactly K cycles. x_rd_en_o=1 and x_addr_o counts 0..K−1. On the last cycle, go to DRAIN.
- DRAIN: lasts exactly LAT cycles with no reads. On its final cycle, go to DONE.
- DONE: one cycle. done_o=1, busy_o=1. Go to IDLE.
- Write path:
  - o_wr_en_o is x_rd_en_o delayed by exactly LAT cycles.
  - o_addr_o starts at 0 each tile and increments after every write.
  - Writes may overlap late FEED cycles when K > LAT.
  - The last write always occurs in the last DRAIN cycle.
- Counters:
  - Each counter clears to 0 when its terminal count is reached while enabled, and on state entry.
  - Counters never wrap past their terminal value.
- start_i is ignored outside IDLE. A start held high across DONE is accepted on the IDLE cycle that follows, never in DONE itself.
- The delay line and write counter flush on every start, so no stale write leaks into the next tile.

## Timing
- Reset (rst_n=0 at a posedge):
  - State = IDLE and all counters and the delay line clear.
  - Every output is 0: busy_o, done_o, w_rd_en_o, w_addr_o, x_rd_en_o, x_addr_o, o_wr_en_o, o_addr_o.
  - Reset mid-tile aborts immediately, with no done_o pulse.
- All outputs are registered. If start is accepted at the posedge ending cycle 0, the first LOAD_W cycle is cycle 1.
- Tile length from the first LOAD_W cycle to the DONE cycle inclusive:
  - ROWS + K + LAT + 1 cycles for K ≥ 1.
  - ROWS + 1 cycles for K = 0.
- Minimum back-to-back spacing: one IDLE cycle between DONE and the next LOAD_W.
- Addresses are held at 0 whenever their enable is 0.

## Test plan
- Reset/idle: hold rst_n=0 for 3 cycles, then release with start_i=0 for 10 cycles → all outputs 0 throughout, state IDLE.
- Single tile, K=3, ROWS=14:
  - Start at cycle 0 → w_rd_en_o cycles 1–14 with w_addr_o 0..13.
  - x_rd_en_o cycles 15–17 with x_addr_o 0..2.
  - o_wr_en_o cycles 42–44 with o_addr_o 0..2.
  - done_o at cycle 45, busy_o low at cycle 46.
- K=0: start at cycle 0 → LOAD_W cycles 1–14, done_o at cycle 15, no x_rd_en_o or o_wr_en_o ever asserted.
- Long tile, K=40:
  - x_rd_en_o cycles 15–54.
  - o_wr_en_o cycles 42–81 (overlapping FEED), with o_addr_o 0..39.
  - done_o at cycle 82.
- Start while busy, plus back-to-back:
  - Pulse start_i at cycle 20 of a K=3 tile → ignored, done_o stays at cycle 45.
  - Holding start_i high from cycle 44 onward → new LOAD_W begins at cycle 47 with K re-latched.
- Reset mid-FEED: drive rst_n=0 at cycle 16 of a K=3 tile → all outputs 0 next cycle, no done_o. A new start then produces a clean tile with o_addr_o beginning at 0.

Source files
------------

// File: rtl/gemm_seq_ctrl.sv
// rtl/gemm_seq_ctrl.sv - tile sequencer for the weight-stationary systolic GEMM array
module gemm_seq_ctrl #(
    parameter int ROWS       = 14,
    parameter int CNT_WIDTH  = 5,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] k_len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  w_rd_en_o,
    output logic [CNT_WIDTH-1:0]  w_addr_o,
    output logic                  x_rd_en_o,
    output logic [ADDR_WIDTH-1:0] x_addr_o,
    output logic                  o_wr_en_o,
    output logic [ADDR_WIDTH-1:0] o_addr_o
);

    localparam int LAT = 2 * ROWS - 1;
    localparam logic [CNT_WIDTH-1:0] W_LAST = CNT_WIDTH'(ROWS - 1);
    localparam logic [CNT_WIDTH-1:0] D_LAST = CNT_WIDTH'(LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_k;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_w_rd_en;
    logic [CNT_WIDTH-1:0]  r_w_addr;
    logic                  r_x_rd_en;
    logic [ADDR_WIDTH-1:0] r_x_addr;
    logic [CNT_WIDTH-1:0]  r_d_cnt;
    logic [LAT-2:0]        r_dly;
    logic                  r_o_wr_en;
    logic [ADDR_WIDTH-1:0] r_o_addr;
    logic                  w_accept;

    assign w_accept = (r_state == S_IDLE) && start_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_w_rd_en <= 1'b0;
            r_w_addr  <= '0;
            r_x_rd_en <= 1'b0;
            r_x_addr  <= '0;
            r_d_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state   <= S_LOAD_W;
                        r_k       <= k_len_i;
                        r_busy    <= 1'b1;
                        r_w_rd_en <= 1'b1;
                        r_w_addr  <= '0;
                    end
                end
                S_LOAD_W: begin
                    if (r_w_addr == W_LAST) begin
                        r_w_rd_en <= 1'b0;
                        r_w_addr  <= '0;
                        if (r_k == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_FEED;
                            r_x_rd_en <= 1'b1;
                            r_x_addr  <= '0;
                        end
                    end else begin
                        r_w_addr <= r_w_addr + CNT_WIDTH'(1);
                    end
                end
                S_FEED: begin
                    if (r_x_addr == r_k - ADDR_WIDTH'(1)) begin
                        r_state   <= S_DRAIN;
                        r_x_rd_en <= 1'b0;
                        r_x_addr  <= '0;
                        r_d_cnt   <= '0;
                    end else begin
                        r_x_addr <= r_x_addr + ADDR_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_d_cnt == D_LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_d_cnt <= '0;
                    end else begin
                        r_d_cnt <= r_d_cnt + CNT_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Write enable trails the feed by exactly LAT cycles; the final stage is r_o_wr_en itself.
    always_ff @(posedge clk) begin
        if (!rst_n || w_accept) begin
            r_dly     <= '0;
            r_o_wr_en <= 1'b0;
            r_o_addr  <= '0;
        end else begin
            r_dly     <= {r_dly[LAT-3:0], r_x_rd_en};
            r_o_wr_en <= r_dly[LAT-2];
            r_o_addr  <= (r_o_wr_en && r_dly[LAT-2]) ? r_o_addr + ADDR_WIDTH'(1) : '0;
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign w_rd_en_o = r_w_rd_en;
    assign w_addr_o  = r_w_addr;
    assign x_rd_en_o = r_x_rd_en;
    assign x_addr_o  = r_x_addr;
    assign o_wr_en_o = r_o_wr_en;
    assign o_addr_o  = r_o_addr;

endmodule
